button_bank_debouncer: RTL

BUTTON_BANK_DEBOUNCER -- requirements
Module: button_bank_debouncer

---
 rtl/button_bank_debouncer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/button_bank_debouncer.sv
// Bank of independent button channels: 2-flop synchronizer, stability-count
// debounce, edge pulses and short/long/auto-repeat press classification.

module button_bank_debouncer_lane #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned LONG_CYC     = 50000000,
    parameter int unsigned REPEAT_CYC   = 10000000,
    parameter bit          RPT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_state,
    output logic btn_pedge,
    output logic btn_nedge,
    output logic btn_short,
    output logic btn_long,
    output logic btn_rpt
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int RPT_W  = $clog2(REPEAT_CYC + 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} fsm_t;

    logic [1:0]        sync_q;
    logic              s;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              state_d;
    logic              db_hit, rise, fall;
    fsm_t              fsm_q, fsm_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic              short_d, long_d, rpt_d;

    assign s = sync_q[1];

    // A level change is accepted only after DEBOUNCE_CYC consecutive mismatches.
    always_comb begin
        db_hit   = (s != btn_state) && (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1));
        state_d  = db_hit ? s : btn_state;
        db_cnt_d = db_cnt_q + 1'b1;
        if (s == btn_state || db_hit)
            db_cnt_d = '0;
        rise = state_d & ~btn_state;
        fall = ~state_d & btn_state;
    end

    always_comb begin
        fsm_d     = fsm_q;
        hold_d    = hold_q;
        rpt_cnt_d = rpt_cnt_q;
        short_d   = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (rise) begin
                    fsm_d  = PRESSED;
                    hold_d = '0;
                    rpt_d  = RPT_EN;
                end
            end
            PRESSED: begin
                // Release wins over reaching the long threshold on the same edge.
                if (fall) begin
                    fsm_d   = IDLE;
                    short_d = 1'b1;
                end else if (hold_q == HOLD_W'(LONG_CYC - 2)) begin
                    fsm_d     = LONG;
                    hold_d    = hold_q + 1'b1;
                    rpt_cnt_d = '0;
                    long_d    = 1'b1;
                    rpt_d     = RPT_EN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    fsm_d = IDLE;
                end else begin
                    if (hold_q != HOLD_W'(LONG_CYC))
                        hold_d = hold_q + 1'b1;
                    if (rpt_cnt_q == RPT_W'(REPEAT_CYC - 1)) begin
                        rpt_cnt_d = '0;
                        rpt_d     = RPT_EN;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            btn_state <= 1'b0;
            fsm_q     <= IDLE;
            hold_q    <= '0;
            rpt_cnt_q <= '0;
            btn_pedge <= 1'b0;
            btn_nedge <= 1'b0;
            btn_short <= 1'b0;
            btn_long  <= 1'b0;
            btn_rpt   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn};
            db_cnt_q  <= db_cnt_d;
            btn_state <= state_d;
            fsm_q     <= fsm_d;
            hold_q    <= hold_d;
            rpt_cnt_q <= rpt_cnt_d;
            btn_pedge <= rise;
            btn_nedge <= fall;
            btn_short <= short_d;
            btn_long  <= long_d;
            btn_rpt   <= rpt_d;
        end
    end
endmodule

module button_bank_debouncer #(
    parameter int unsigned      N_BTN        = 6,
    parameter int unsigned      DEBOUNCE_CYC = 1000000,
    parameter int unsigned      LONG_CYC     = 50000000,
    parameter int unsigned      REPEAT_CYC   = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 6'b000100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] btn_pedge,
    output logic [N_BTN-1:0] btn_nedge,
    output logic [N_BTN-1:0] btn_short,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_rpt
);
    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_lane
        button_bank_debouncer_lane #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_CYC  (REPEAT_CYC),
            .RPT_EN      (REPEAT_MASK[i])
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .btn      (btn[i]),
            .btn_state(btn_state[i]),
            .btn_pedge(btn_pedge[i]),
            .btn_nedge(btn_nedge[i]),
            .btn_short(btn_short[i]),
            .btn_long (btn_long[i]),
            .btn_rpt  (btn_rpt[i])
        );
    end
endmodule
